// File: rtl/calc_pkg.sv
// Shared opcode, state and constant definitions for the calculator controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Wide enough to hold lat-1 for the largest legal multiply/divide latency (15).
    localparam int CNT_W = 4;

    localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit adder/subtractor; in subtract mode carry=1 means no borrow.
// Latency: combinational.
// Backpressure: none.
module adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_sub_en,
    output logic [15:0] o_sum,
    output logic        o_carry
);

    logic [15:0] w_b;

    // Two's complement subtract: invert B and inject the +1 as carry-in.
    assign w_b = i_sub_en ? ~i_b : i_b;
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {16'd0, i_sub_en};

endmodule

// File: rtl/calc_datapath.sv
// Arithmetic core wrapper: selects add/sub/mul/div result and flags by opcode.
// Latency: combinational.
// Backpressure: none; controller holds inputs stable while it waits.
module calc_datapath
    import calc_pkg::*;
(
    input  logic [1:0]  i_op_code,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_result,
    output logic        o_carry,
    output logic        o_div_zero
);

    logic [15:0] w_sum;
    logic        w_add_carry;
    logic [15:0] w_prod;
    logic [15:0] w_quot;
    logic        w_b_zero;

    adder_16bit u_adder (
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sub_en (i_op_code == OP_SUB),
        .o_sum    (w_sum),
        .o_carry  (w_add_carry)
    );

    multiplier_8bit u_mul (
        .i_a    (i_a[7:0]),
        .i_b    (i_b[7:0]),
        .o_prod (w_prod)
    );

    divider_8bit u_div (
        .i_a    (i_a[7:0]),
        .i_b    (i_b[7:0]),
        .o_quot (w_quot)
    );

    assign w_b_zero = (i_b[7:0] == 8'd0);

    // Opcode mux; carry is meaningful only for add/sub, div_zero only for div.
    always_comb begin
        o_result   = 16'd0;
        o_carry    = 1'b0;
        o_div_zero = 1'b0;
        case (i_op_code)
            OP_ADD, OP_SUB: begin
                o_result = w_sum;
                o_carry  = w_add_carry;
            end
            OP_MUL: begin
                o_result = w_prod;
            end
            OP_DIV: begin
                o_result   = w_b_zero ? DIV_ZERO_RESULT : w_quot;
                o_div_zero = w_b_zero;
            end
            default: begin
                o_result = 16'd0;
            end
        endcase
    end

endmodule

// File: rtl/divider_8bit.sv
// 8-bit signed divider, quotient truncated toward zero and sign-extended to 16 bits.
// Latency: combinational (caller allows settle time).
// Backpressure: none.
module divider_8bit (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_quot
);

    logic signed [15:0] w_a;
    logic signed [15:0] w_b;
    logic signed [15:0] w_b_safe;
    logic signed [15:0] w_q;

    assign w_a = {{8{i_a[7]}}, i_a};
    assign w_b = {{8{i_b[7]}}, i_b};
    // A zero divisor is replaced so the quotient never goes X; the caller
    // substitutes the divide-by-zero result anyway.
    assign w_b_safe = (i_b == 8'd0) ? 16'sd1 : w_b;
    // Working in 16 bits keeps -128 / -1 = +128 representable.
    assign w_q    = w_a / w_b_safe;
    assign o_quot = w_q;

endmodule

// File: rtl/multiplier_8bit.sv
// 8x8 unsigned multiplier with full 16-bit product.
// Latency: combinational (caller allows settle time).
// Backpressure: none.
module multiplier_8bit (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_prod
);

    assign o_prod = {8'd0, i_a} * {8'd0, i_b};

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: accept one op, wait its latency, hold registered result until acked.
// Latency: result valid after accept edge + 1 (add/sub) or + MULDIV_LAT (mul/div).
// Backpressure: DONE holds result/flags indefinitely; no new op accepted until the cycle after ack.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int MULDIV_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic        use_acc,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        carry,
    output logic        div_zero
);

    localparam logic [CNT_W-1:0] MULDIV_CNT_INIT = CNT_W'(MULDIV_LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic [15:0]       r_acc;
    logic [15:0]       r_result;
    logic              r_carry;
    logic              r_div_zero;

    logic              w_accept;
    logic              w_finish;
    logic [CNT_W-1:0]  w_cnt_init;
    logic [15:0]       w_dp_result;
    logic              w_dp_carry;
    logic              w_dp_div_zero;

    assign w_accept   = (r_state == ST_IDLE) && op_valid;
    assign w_finish   = (r_state == ST_EXEC) && (r_cnt == '0);
    // Opcode bit 1 set means mul/div, which get the configurable settle time.
    assign w_cnt_init = op_code[1] ? MULDIV_CNT_INIT : '0;

    // Datapath sees only captured operands so late input changes cannot disturb it.
    calc_datapath u_datapath (
        .i_op_code  (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result   (w_dp_result),
        .o_carry    (w_dp_carry),
        .o_div_zero (w_dp_div_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ready and valid are mutually exclusive by state.
    always_comb begin
        w_next_state = r_state;
        op_ready     = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture opcode and operands on accept; A comes from the accumulator when requested.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op <= OP_ADD;
            r_a  <= 16'd0;
            r_b  <= 16'd0;
        end else if (w_accept) begin
            r_op <= op_code;
            r_a  <= use_acc ? r_acc : op_a;
            r_b  <= op_b;
        end
    end

    // Latency counter: load lat-1 on accept, count down while executing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_init;
        end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result, flags and accumulator update only on EXEC->DONE, so they hold through backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result   <= 16'd0;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= 16'd0;
        end else if (w_finish) begin
            r_result   <= w_dp_result;
            r_carry    <= w_dp_carry;
            r_div_zero <= w_dp_div_zero;
            r_acc      <= w_dp_result;
        end
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign div_zero = r_div_zero;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the calculator arithmetic core. It accepts one operation at a time over a valid/ready handshake and routes the operands to the 16-bit adder/subtractor, 8-bit multiplier or 8-bit signed divider. It waits a per-operation latency, then registers the result and flags and holds them until the consumer acknowledges. An internal accumulator lets operations chain, so the previous result can be used as operand A.

## Interface
- MULDIV_LAT, default 2: cycles allowed for multiply and divide to settle. Legal range 1..15. Add and subtract always take 1 cycle.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- op_valid  input  1  request valid.
- op_ready  output  1  controller can accept a request.
- op_code  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- use_acc  input  1  when 1, operand A is the accumulator and op_a is ignored.
- op_a  input  16  operand A.
- op_b  input  16  operand B.
- res_valid  output  1  result, carry and div_zero are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  16  registered result.
- carry  output  1  add: carry out. Sub: 1 means no borrow, 0 means borrow. 0 for mul and div.
- div_zero  output  1  divide attempted with zero divisor.

## Operation
- State machine states: IDLE, EXEC, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid, capture op_code, A (op_a or accumulator) and op_b into internal registers.
  - Load the latency counter with lat-1, where lat = 1 for add/sub and MULDIV_LAT for mul/div.
  - Go to EXEC.
- EXEC:
  - op_ready=0. The datapath is driven only from the captured registers.
  - When the counter reaches 0, register result, carry and div_zero; copy result into the accumulator; go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - res_valid=1; result and flags are held stable.
  - When res_ready=1, go to IDLE.
  - The request side is not accepted in the same cycle (no bypass). op_ready rises the cycle after the result handshake.
- Arithmetic rules:
  - Add and sub use the full 16-bit operands; the result wraps modulo 2^16.
  - Mul: A[7:0] × B[7:0], unsigned, with a 16-bit product.
  - Div:
    - A[7:0] and B[7:0] are sign-extended; the quotient is signed and truncates toward zero.
    - If B[7:0]==0, result=16'hFFFE and div_zero=1. Both are registered like a normal result; no other error path exists.
- Accumulator:
  - 16-bit, reset to 0.
  - Updated only on the EXEC→DONE transition.
  - use_acc in IDLE reads the value left by the last completed operation.
- Only the sampled inputs matter. op_* and use_acc are ignored outside the IDLE accept cycle, and res_ready is ignored outside DONE.

## Timing
- Reset values: state=IDLE, op_ready=1 from the first cycle after reset, res_valid=0, result=0, carry=0, div_zero=0, accumulator=0, counter=0.
- Reset mid-EXEC or mid-DONE: on the next edge, return to IDLE, drop the pending result and clear the accumulator.
- Latency: with the accept at edge T, res_valid is high after edge T+lat. That is T+1 for add/sub and T+MULDIV_LAT for mul/div.
- Throughput:
  - One operation per lat+2 cycles when res_ready is held high.
  - Back-to-back add ops: accept, EXEC, DONE+handshake, then IDLE accept again. That is one op every 3 cycles.
- Backpressure: DONE may last any number of cycles. result and flags must not change while res_valid=1 and res_ready=0.
- op_ready and res_valid are never high in the same cycle.

## Structure
- Shared package calc_pkg holds:
  - op_code localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - State encoding for IDLE, EXEC and DONE.
  - DIV_ZERO_RESULT=16'hFFFE.
- Sub-module calc_datapath: a purely combinational wrapper.
  - Instantiates the existing adder_16bit (sub_en driven from op_code==OP_SUB), multiplier_8bit and divider_8bit.
  - Muxes their outputs by op_code and produces div_zero.
- calc_ctrl contains the FSM, the counter, the capture registers, the accumulator and the output registers.

## Test plan
- Add: op_a=16'h1234, op_b=16'h0001, accept at edge T. Expect result=16'h1235, carry=0, res_valid high after edge T+1.
- Sub, two cases:
  - 5−7: expect result=16'hFFFE, carry=0 (borrow).
  - 7−5: expect result=16'h0002, carry=1.
- Mul: op_a=16'h00FF, op_b=16'h00FF, MULDIV_LAT=2. Expect result=16'hFE01 after edge T+2, and op_ready=0 throughout.
- Div, two cases:
  - op_a=16'h00F9 (−7), op_b=16'h0002: expect result=16'hFFFD (−3), div_zero=0.
  - op_b=0: expect result=16'hFFFE, div_zero=1.
- Backpressure and chaining:
  - Add 3+4, then hold res_ready=0 for 5 cycles. Expect result=7, stable, with op_ready=0.
  - Release res_ready, then issue sub with use_acc=1, op_a=16'hDEAD, op_b=2. Expect result=5.
- Reset mid-operation: drop rst_n during EXEC of a mul. Expect IDLE, op_ready=1 and res_valid=0 on the next cycle. A following use_acc add with op_b=1 must then give result=1.
